// File: rtl/motor_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// motor_ctrl_pkg
// Shared definitions for the motor command path: the arbiter state encoding
// and the default duty resolution used by the arbiter and the PWM generators.
// No ports (package).
// ---------------------------------------------------------------------------
package motor_ctrl_pkg;

    // Default duty resolution: 0 = off, 2^W-1 = full drive.
    localparam int MOTOR_DUTY_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RAMP  = 2'd1,
        ARB_HOLD  = 2'd2,
        ARB_ESTOP = 2'd3
    } motor_arb_state_t;

endpackage

// File: rtl/motor_duty_ramp.sv
// ---------------------------------------------------------------------------
// motor_duty_ramp
// One motor channel's slew limiter. When step_en is high the duty moves
// toward the target by at most RAMP_STEP, landing exactly on the target
// when it is closer than that (no overshoot, no wrap).
//
// Ports:
//   duty      in  DUTY_WIDTH  current registered duty
//   target    in  DUTY_WIDTH  duty being ramped toward
//   step_en   in  1           apply one ramp step this cycle
//   duty_next out DUTY_WIDTH  duty to register next (duty when not stepping)
//   at_target out 1           duty_next equals target
// ---------------------------------------------------------------------------
module motor_duty_ramp
    import motor_ctrl_pkg::*;
#(
    parameter int DUTY_WIDTH = MOTOR_DUTY_WIDTH,
    parameter int RAMP_STEP  = 4
) (
    input  logic [DUTY_WIDTH-1:0] duty,
    input  logic [DUTY_WIDTH-1:0] target,
    input  logic                  step_en,
    output logic [DUTY_WIDTH-1:0] duty_next,
    output logic                  at_target
);

    localparam logic signed [DUTY_WIDTH:0] STEP_S = (DUTY_WIDTH+1)'(RAMP_STEP);

    // The difference is formed one bit wider than the duty so that both
    // directions are representable; clamping to the target keeps the result
    // inside the unsigned duty range.
    function automatic logic [DUTY_WIDTH-1:0] sat_step(
        input logic [DUTY_WIDTH-1:0] cur,
        input logic [DUTY_WIDTH-1:0] tgt
    );
        logic signed [DUTY_WIDTH:0] diff;
        logic signed [DUTY_WIDTH:0] res;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) begin
            res = $signed({1'b0, cur}) + STEP_S;
        end else if (diff < -STEP_S) begin
            res = $signed({1'b0, cur}) - STEP_S;
        end else begin
            res = $signed({1'b0, tgt});
        end
        return res[DUTY_WIDTH-1:0];
    endfunction

    assign duty_next = step_en ? sat_step(duty, target) : duty;
    assign at_target = (duty_next == target);

endmodule

// File: rtl/motor_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// motor_cmd_arbiter
// Shares the left/right motor drive between NUM_REQ command sources with
// fixed priority (index 0 highest) and owner lock-out, slew-limits the duty
// toward the accepted targets, ramps to stop when commands stop arriving,
// and zeroes the drive immediately on emergency stop.
//
// Ports:
//   clk            in  1                  block clock
//   reset_n        in  1                  asynchronous active-low reset
//   estop          in  1                  emergency stop (level, synchronous)
//   req_valid      in  NUM_REQ            command valid per requester
//   req_ready      out NUM_REQ            one-hot accept strobe
//   req_left_duty  in  NUM_REQ*DUTY_WIDTH packed left targets
//   req_right_duty in  NUM_REQ*DUTY_WIDTH packed right targets
//   left_duty      out DUTY_WIDTH         registered left duty
//   right_duty     out DUTY_WIDTH         registered right duty
//   owner_valid    out 1                  a requester owns the motors
//   owner_id       out ID_W               owning requester index
//   ramp_busy      out 1                  ramping toward the targets
//   timeout_flag   out 1                  watchdog fired since last accept
// ---------------------------------------------------------------------------
module motor_cmd_arbiter
    import motor_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int DUTY_WIDTH     = MOTOR_DUTY_WIDTH,
    parameter int RAMP_STEP      = 4,
    parameter int RAMP_DIV       = 256,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          estop,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DUTY_WIDTH-1:0] req_left_duty,
    input  logic [NUM_REQ*DUTY_WIDTH-1:0] req_right_duty,
    output logic [DUTY_WIDTH-1:0]         left_duty,
    output logic [DUTY_WIDTH-1:0]         right_duty,
    output logic                          owner_valid,
    output logic [ID_W-1:0]               owner_id,
    output logic                          ramp_busy,
    output logic                          timeout_flag
);

    localparam int DIV_W = $clog2(RAMP_DIV);
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RAMP_DIV - 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT_CYCLES - 1);

    motor_arb_state_t state, state_n;

    logic [DUTY_WIDTH-1:0] left_tgt, right_tgt, left_tgt_n, right_tgt_n;
    logic [DUTY_WIDTH-1:0] left_duty_n, right_duty_n;
    logic [DUTY_WIDTH-1:0] left_step, right_step;
    logic [DUTY_WIDTH-1:0] acc_left, acc_right;
    logic                  left_at, right_at;
    logic                  accept, tick;
    logic [ID_W-1:0]       acc_id, owner_id_n;
    logic                  owner_valid_n, timeout_flag_n;
    logic [DIV_W-1:0]      div_cnt, div_n, div_inc;
    logic [WD_W-1:0]       wd_cnt, wd_n;

    // Priority grant: the first valid requester that is not locked out by a
    // higher-priority owner. Nothing is granted while stopping or stopped.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        acc_id    = '0;
        acc_left  = '0;
        acc_right = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!accept && req_valid[i] && (state != ARB_ESTOP) && !estop &&
                (!owner_valid || (i <= int'(owner_id)))) begin
                req_ready[i] = 1'b1;
                accept       = 1'b1;
                acc_id       = ID_W'(i);
                acc_left     = req_left_duty[i*DUTY_WIDTH +: DUTY_WIDTH];
                acc_right    = req_right_duty[i*DUTY_WIDTH +: DUTY_WIDTH];
            end
        end
    end

    assign tick      = (state == ARB_RAMP) && (div_cnt == DIV_MAX);
    assign div_inc   = (div_cnt == DIV_MAX) ? '0 : div_cnt + DIV_W'(1);
    assign ramp_busy = (state == ARB_RAMP);

    motor_duty_ramp #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .RAMP_STEP  (RAMP_STEP)
    ) u_ramp_left (
        .duty      (left_duty),
        .target    (left_tgt),
        .step_en   (tick),
        .duty_next (left_step),
        .at_target (left_at)
    );

    motor_duty_ramp #(
        .DUTY_WIDTH (DUTY_WIDTH),
        .RAMP_STEP  (RAMP_STEP)
    ) u_ramp_right (
        .duty      (right_duty),
        .target    (right_tgt),
        .step_en   (tick),
        .duty_next (right_step),
        .at_target (right_at)
    );

    always_comb begin
        state_n        = state;
        left_tgt_n     = left_tgt;
        right_tgt_n    = right_tgt;
        left_duty_n    = left_duty;
        right_duty_n   = right_duty;
        owner_valid_n  = owner_valid;
        owner_id_n     = owner_id;
        timeout_flag_n = timeout_flag;
        // Both counters idle at zero outside the state that uses them, so
        // every entry into RAMP or HOLD starts a fresh count.
        div_n          = '0;
        wd_n           = '0;

        if (estop) begin
            state_n       = ARB_ESTOP;
            left_duty_n   = '0;
            right_duty_n  = '0;
            left_tgt_n    = '0;
            right_tgt_n   = '0;
            owner_valid_n = 1'b0;
        end else if (state == ARB_ESTOP) begin
            state_n = ARB_IDLE;
        end else if (accept) begin
            left_tgt_n     = acc_left;
            right_tgt_n    = acc_right;
            owner_id_n     = acc_id;
            owner_valid_n  = 1'b1;
            timeout_flag_n = 1'b0;
            // A retarget during a ramp keeps the tick cadence running; the
            // duties themselves hold for this one cycle and resume stepping
            // toward the new targets from the next tick on.
            if (state == ARB_RAMP) begin
                div_n = div_inc;
            end
            if ((acc_left != left_duty) || (acc_right != right_duty)) begin
                state_n = ARB_RAMP;
            end else if ((state == ARB_IDLE) && (acc_left == '0) && (acc_right == '0)) begin
                state_n       = ARB_IDLE;
                owner_valid_n = 1'b0;
            end else begin
                state_n = ARB_HOLD;
            end
        end else begin
            case (state)
                ARB_RAMP: begin
                    div_n        = div_inc;
                    left_duty_n  = left_step;
                    right_duty_n = right_step;
                    if (left_at && right_at) begin
                        if ((left_tgt == '0) && (right_tgt == '0)) begin
                            state_n       = ARB_IDLE;
                            owner_valid_n = 1'b0;
                        end else begin
                            state_n = ARB_HOLD;
                        end
                    end
                end
                ARB_HOLD: begin
                    // Loss of commands: ramp to stop but keep the owner so a
                    // lower-priority source cannot grab the motors mid-ramp.
                    if (wd_cnt == WD_MAX) begin
                        left_tgt_n     = '0;
                        right_tgt_n    = '0;
                        timeout_flag_n = 1'b1;
                        state_n        = ARB_RAMP;
                    end else begin
                        wd_n = wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ARB_IDLE;
            left_tgt     <= '0;
            right_tgt    <= '0;
            left_duty    <= '0;
            right_duty   <= '0;
            owner_valid  <= 1'b0;
            owner_id     <= '0;
            timeout_flag <= 1'b0;
            div_cnt      <= '0;
            wd_cnt       <= '0;
        end else begin
            state        <= state_n;
            left_tgt     <= left_tgt_n;
            right_tgt    <= right_tgt_n;
            left_duty    <= left_duty_n;
            right_duty   <= right_duty_n;
            owner_valid  <= owner_valid_n;
            owner_id     <= owner_id_n;
            timeout_flag <= timeout_flag_n;
            div_cnt      <= div_n;
            wd_cnt       <= wd_n;
        end
    end

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_motor_cmd_arbiter
// Bench for motor_cmd_arbiter: grant table, directed multi-cycle scenarios
// and randomized traffic, all compared every cycle against a behavioural
// model of the arbiter kept in plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_motor_cmd_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 8;
    localparam int STEP = 4;
    localparam int DIV  = 16;
    localparam int TO   = 100;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            estop = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ-1:0] req_ready;
    logic [DW-1:0]   lreq [NREQ];
    logic [DW-1:0]   rreq [NREQ];
    logic [NREQ*DW-1:0] req_left_duty, req_right_duty;
    logic [DW-1:0]   left_duty, right_duty;
    logic            owner_valid;
    logic [1:0]      owner_id;
    logic            ramp_busy, timeout_flag;

    always #5 clk = ~clk;

    always_comb begin
        req_left_duty  = '0;
        req_right_duty = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_left_duty[i*DW +: DW]  = lreq[i];
            req_right_duty[i*DW +: DW] = rreq[i];
        end
    end

    motor_cmd_arbiter #(
        .NUM_REQ        (NREQ),
        .DUTY_WIDTH     (DW),
        .RAMP_STEP      (STEP),
        .RAMP_DIV       (DIV),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .estop          (estop),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_left_duty  (req_left_duty),
        .req_right_duty (req_right_duty),
        .left_duty      (left_duty),
        .right_duty     (right_duty),
        .owner_valid    (owner_valid),
        .owner_id       (owner_id),
        .ramp_busy      (ramp_busy),
        .timeout_flag   (timeout_flag)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_STOP = 3;
    int m_mode, m_l, m_r, m_tl, m_tr, m_ov, m_oid, m_flag, m_phase, m_hold;

    task automatic model_reset();
        m_mode = M_IDLE; m_l = 0; m_r = 0; m_tl = 0; m_tr = 0;
        m_ov = 0; m_oid = 0; m_flag = 0; m_phase = 0; m_hold = 0;
    endtask

    function automatic int toward(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (d > STEP)  d = STEP;
        if (d < -STEP) d = -STEP;
        return cur + d;
    endfunction

    function automatic int model_grant();
        if (m_mode == M_STOP || estop) return -1;
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && (m_ov == 0 || i <= m_oid)) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_ready();
        int g;
        g = model_grant();
        return (g < 0) ? 32'd0 : (32'd1 << g);
    endfunction

    task automatic model_step();
        int g, prev;
        g = model_grant();
        prev = m_mode;
        if (estop) begin
            m_mode = M_STOP; m_l = 0; m_r = 0; m_tl = 0; m_tr = 0;
            m_ov = 0; m_phase = 0; m_hold = 0;
        end else if (m_mode == M_STOP) begin
            m_mode = M_IDLE;
        end else if (g >= 0) begin
            m_tl = int'(lreq[g]); m_tr = int'(rreq[g]);
            m_oid = g; m_ov = 1; m_flag = 0; m_hold = 0;
            if (m_tl != m_l || m_tr != m_r) m_mode = M_RAMP;
            else if (prev == M_IDLE && m_tl == 0 && m_tr == 0) m_ov = 0;
            else m_mode = M_HOLD;
            m_phase = (prev == M_RAMP && m_mode == M_RAMP) ? (m_phase + 1) % DIV : 0;
        end else if (m_mode == M_RAMP) begin
            if (m_phase == DIV - 1) begin
                m_l = toward(m_l, m_tl);
                m_r = toward(m_r, m_tr);
            end
            m_phase = (m_phase + 1) % DIV;
            if (m_l == m_tl && m_r == m_tr) begin
                if (m_tl == 0 && m_tr == 0) begin m_mode = M_IDLE; m_ov = 0; end
                else m_mode = M_HOLD;
                m_hold = 0;
            end
        end else if (m_mode == M_HOLD) begin
            if (m_hold == TO - 1) begin
                m_tl = 0; m_tr = 0; m_flag = 1; m_mode = M_RAMP; m_phase = 0; m_hold = 0;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("left_duty",    left_duty,    m_l);
        chk("right_duty",   right_duty,   m_r);
        chk("owner_valid",  owner_valid,  m_ov);
        chk("owner_id",     owner_id,     m_oid);
        chk("ramp_busy",    ramp_busy,    (m_mode == M_RAMP) ? 1 : 0);
        chk("timeout_flag", timeout_flag, m_flag);
    endtask

    // One clock: ready checked before the edge, outputs 1 ns after it.
    task automatic cyc();
        #1;
        chk("req_ready", req_ready, model_ready());
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic wait_hold(input int budget);
        int n;
        n = 0;
        while (ramp_busy && n < budget) begin cyc(); n++; end
        chk("wait_hold_busy", ramp_busy, 0);
    endtask

    task automatic wait_left(input int val, input int budget);
        int n;
        n = 0;
        while (int'(left_duty) != val && n < budget) begin cyc(); n++; end
        chk("wait_left_duty", left_duty, val);
    endtask

    // ---------------- grant table ----------------
    typedef struct {
        logic       est;
        logic [2:0] vld;
        logic [2:0] rdy_free;   // no owner
        logic [2:0] rdy_own1;   // requester 1 owns the motors
    } rdy_vec_t;
    rdy_vec_t tbl [9];

    task automatic apply_table(input bit own1);
        for (int i = 0; i < 9; i++) begin
            estop = tbl[i].est;
            req_valid = tbl[i].vld;
            #1;
            chk($sformatf("ready_tbl%0d_own%0d", i, own1), req_ready,
                own1 ? tbl[i].rdy_own1 : tbl[i].rdy_free);
            estop = 1'b0;
            req_valid = '0;
            cyc();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int est_left, rate, pick;
        tbl[0] = '{1'b0, 3'b000, 3'b000, 3'b000};
        tbl[1] = '{1'b0, 3'b001, 3'b001, 3'b001};
        tbl[2] = '{1'b0, 3'b010, 3'b010, 3'b010};
        tbl[3] = '{1'b0, 3'b011, 3'b001, 3'b001};
        tbl[4] = '{1'b0, 3'b100, 3'b100, 3'b000};
        tbl[5] = '{1'b0, 3'b101, 3'b001, 3'b001};
        tbl[6] = '{1'b0, 3'b110, 3'b010, 3'b010};
        tbl[7] = '{1'b0, 3'b111, 3'b001, 3'b001};
        tbl[8] = '{1'b1, 3'b111, 3'b000, 3'b000};
        for (int i = 0; i < NREQ; i++) begin lreq[i] = 8'd77; rreq[i] = 8'd77; end
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_ready", req_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        apply_table(1'b0);

        // single command from requester 1
        lreq[1] = 8'd40; rreq[1] = 8'd40; req_valid = 3'b010;
        #1;
        chk("s1_ready", req_ready, 3'b010);
        cyc();
        req_valid = '0;
        chk("s1_owner", owner_id, 1);
        chk("s1_busy", ramp_busy, 1);
        repeat (DIV - 1) cyc();
        chk("s1_pre_tick", left_duty, 0);
        cyc();
        chk("s1_tick1", left_duty, 4);
        repeat (9 * DIV) cyc();
        chk("s1_left40", left_duty, 40);
        chk("s1_right40", right_duty, 40);
        chk("s1_hold", ramp_busy, 0);

        // lockout, then preemption by requester 0
        apply_table(1'b1);
        lreq[2] = 8'd200; rreq[2] = 8'd200; req_valid = 3'b100;
        #1;
        chk("lock_ready", req_ready, 0);
        repeat (2) cyc();
        chk("lock_duty", left_duty, 40);
        chk("lock_owner", owner_id, 1);
        lreq[0] = 8'd0; rreq[0] = 8'd0; req_valid = 3'b101;
        #1;
        chk("pre_ready", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        chk("pre_owner", owner_id, 0);
        chk("pre_busy", ramp_busy, 1);
        repeat (10 * DIV) cyc();
        chk("pre_left0", left_duty, 0);
        chk("pre_released", owner_valid, 0);
        chk("pre_idle", ramp_busy, 0);

        // asymmetric ramp
        lreq[0] = 8'd10; rreq[0] = 8'd3; req_valid = 3'b001;
        cyc();
        req_valid = '0;
        repeat (DIV) cyc();
        chk("asym_l4", left_duty, 4);
        chk("asym_r3", right_duty, 3);
        repeat (DIV) cyc();
        chk("asym_l8", left_duty, 8);
        chk("asym_busy", ramp_busy, 1);
        repeat (DIV) cyc();
        chk("asym_l10", left_duty, 10);
        chk("asym_hold", ramp_busy, 0);

        // watchdog
        lreq[0] = 8'd20; rreq[0] = 8'd20; req_valid = 3'b001;
        cyc();
        req_valid = '0;
        wait_hold(20 * DIV);
        chk("wd_left20", left_duty, 20);
        repeat (TO - 1) cyc();
        chk("wd_before", timeout_flag, 0);
        cyc();
        chk("wd_fired", timeout_flag, 1);
        chk("wd_ramp", ramp_busy, 1);
        chk("wd_owner_kept", owner_valid, 1);
        lreq[0] = 8'd100; rreq[0] = 8'd100; req_valid = 3'b001;
        cyc();
        req_valid = '0;
        chk("wd_cleared", timeout_flag, 0);
        wait_left(60, 40 * DIV);

        // emergency stop mid-ramp with requester 0 offering
        lreq[0] = 8'd50; rreq[0] = 8'd50; req_valid = 3'b001; estop = 1'b1;
        #1;
        chk("es_ready", req_ready, 0);
        cyc();
        chk("es_left0", left_duty, 0);
        chk("es_right0", right_duty, 0);
        chk("es_owner", owner_valid, 0);
        repeat (2) cyc();
        estop = 1'b0;
        #1;
        chk("es_rel_ready", req_ready, 0);
        cyc();
        chk("es_idle", ramp_busy, 0);
        #1;
        chk("es_acc_ready", req_ready, 3'b001);
        cyc();
        req_valid = '0;
        chk("es_acc_owner", owner_valid, 1);
        chk("es_acc_busy", ramp_busy, 1);

        // asynchronous reset mid-HOLD
        wait_hold(40 * DIV);
        repeat (5) cyc();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("ar_left", left_duty, 0);
        chk("ar_right", right_duty, 0);
        chk("ar_owner_valid", owner_valid, 0);
        chk("ar_owner_id", owner_id, 0);
        chk("ar_busy", ramp_busy, 0);
        chk("ar_flag", timeout_flag, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        chk("ar_idle", ramp_busy, 0);

        // randomized traffic
        est_left = 0;
        for (int c = 0; c < 8000; c++) begin
            if (est_left > 0) begin
                estop = 1'b1;
                est_left--;
            end else begin
                estop = 1'b0;
                if ($urandom_range(0, 599) == 0) est_left = $urandom_range(1, 4);
            end
            rate = (c < 4000) ? 30 : 300;
            if ($urandom_range(0, rate - 1) == 0) begin
                req_valid = 3'($urandom_range(1, 7));
                for (int i = 0; i < NREQ; i++) begin
                    pick = $urandom_range(0, 3);
                    if (pick == 0) begin
                        lreq[i] = 8'(m_l); rreq[i] = 8'(m_r);
                    end else if (pick == 1) begin
                        lreq[i] = 8'd0; rreq[i] = 8'd0;
                    end else begin
                        lreq[i] = 8'($urandom_range(0, 255));
                        rreq[i] = 8'($urandom_range(0, 255));
                    end
                end
            end else begin
                req_valid = '0;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
